ucsbece154_icache: RTL
======================

UCSBECE154_ICACHE -- requirements
Module: ucsbece154_icache

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset named reset.
REQ-002 Parameter NUM_SETS, default 8: number of sets, a power of 2.
REQ-003 Parameter NUM_WAYS, default 2: associativity, fixed at 2 in this revision.
REQ-004 Parameter BLOCK_WORDS, default 4: 32-bit words per line; it SHALL match the memory burst length.
REQ-005 Parameter ADVANCED, default 0: 1 means memory returns the critical word first; it SHALL match the memory setting.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock
- reset  in  1  async active-low reset
- ReadEnable  in  1  CPU fetch request
- ReadAddress  in  32  CPU fetch byte address, word-aligned
- Instruction  out  32  fetched word
- Ready  out  1  Instruction valid this cycle
- MemReadRequest  out  1  burst request to memory
- MemReadAddress  out  32  miss word address, including the critical offset
- MemDataIn  in  32  burst beat data
- MemDataReady  in  1  burst beat valid

Function
REQ-007 Address split: offset = addr[3:2]; index = addr[4 +: log2(NUM_SETS)]; tag = the remaining upper bits.
REQ-008 Hit: ReadEnable is high, the state is IDLE, and a valid way's tag matches; Ready and Instruction SHALL then be driven combinationally in the same cycle (0-cycle hit latency).
REQ-009 Miss in IDLE: latch the address, select the victim, clear the victim's valid bit, and go to WAIT next cycle; Ready stays 0.
REQ-010 WAIT: hold MemReadRequest=1 and MemReadAddress=latched address until the first MemDataReady, because memory ignores requests while a previous burst is draining.
REQ-011 FILL: on each MemDataReady beat k (0..BLOCK_WORDS-1), write MemDataIn to the line word given by the beat-offset map.
REQ-012 Beat-offset map when ADVANCED=0: offset = k.
REQ-013 Beat-offset map when ADVANCED=1:
- beat 0 carries the critical word, offset = crit;
- beat k>=1 carries offset k-1 if k-1<crit, otherwise k.
REQ-014 Early restart: on the beat whose offset equals the latched offset, Ready=1 and Instruction=MemDataIn in that cycle, exactly once per miss.
REQ-015 After the last beat, write the tag and set the valid bit, update LRU so the filled way is most recent, and return to IDLE next cycle.
REQ-016 MemDataReady seen in IDLE, and beats beyond BLOCK_WORDS, SHALL be ignored.
REQ-017 Replacement: choose an invalid way first (way 0 before way 1); otherwise choose the LRU way.
REQ-018 LRU: one bit per set, updated on every hit and every fill.
REQ-019 While in WAIT or FILL, Ready=0 except for the early-restart beat; changes on ReadAddress SHALL NOT affect the fill in progress.
REQ-020 When ReadEnable=0, Ready=0 and no state change occurs.
REQ-021 States are IDLE, WAIT and FILL, held in a 2-bit encoding; the beat counter is log2(BLOCK_WORDS)+1 bits wide.

Reset
REQ-022 Asserting reset low SHALL immediately:
- set the state to IDLE;
- clear all valid and LRU bits and the beat counter;
- drive Ready=0, MemReadRequest=0, Instruction=0.
REQ-023 Reset during WAIT or FILL SHALL abandon the fill; the partially written line SHALL remain invalid.
REQ-024 Tag and data arrays SHALL NOT require reset.

Structure
REQ-025 The shared package ucsbece154_cache_pkg SHALL hold the state encodings, TEXT_START (0x00010000) and the address-field width functions.
REQ-026 The FSM, beat counter and beat-offset map SHALL live in sub-module ucsbece154_icache_fill; the arrays and hit logic SHALL stay in the top module.

Verification
REQ-027 The bench SHALL use the memory model with T0_DELAY=40, text at 0x00010000, and TEXT[i]=0x1000+i. It SHALL cover these directed scenarios:
- Cold miss on 0x00010008, ADVANCED=0 -> MemReadRequest rises next cycle; Ready on beat 2 with 0x1002; a fetch of 0x0001000C after the fill hits in the same cycle with 0x1003.
- Cold miss on 0x00010008, ADVANCED=1 -> Ready on beat 0 with 0x1002; line words 0, 1, 3 filled from beats 1, 2, 3; later hits on 0x00010000 and 0x00010004 return 0x1000 and 0x1001.
- Fill 0x00010000 and 0x00010080 (set 0, two tags), re-touch 0x00010080, then miss 0x00010100 -> the 0x00010000 way is evicted; 0x00010080 still hits.
- Miss issued the cycle after a fill completes -> MemReadRequest stays high until the memory starts the new burst; no request is lost; correct data returned.
- Reset driven low on beat 2 of a fill on 0x00010040 -> Ready=0 and MemReadRequest=0 immediately; after release, 0x00010040 misses again.
- Hold ReadEnable=0 while MemDataReady pulses in IDLE -> no array writes, Ready stays 0.

Source files
------------

// File: rtl/ucsbece154_cache_pkg.sv
// Shared cache definitions: fill FSM state encoding, text base address, address-field widths.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package ucsbece154_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FILL = 2'd2
    } fill_state_t;

    localparam logic [31:0] TEXT_START = 32'h0001_0000;

    // Word-within-line field width.
    function automatic int offset_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    // Set-index field width.
    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag is everything above byte offset, word offset and index.
    function automatic int tag_bits(input int num_sets, input int block_words);
        return 32 - 2 - offset_bits(block_words) - index_bits(num_sets);
    endfunction

endpackage

// File: rtl/ucsbece154_icache_fill.sv
// Miss handler: IDLE/WAIT/FILL FSM, beat counter and beat-to-line-word offset map.
// Latency: request asserted the cycle after a miss; one line write per MemDataReady beat.
// Backpressure: request held through WAIT until the first beat; beats outside WAIT/FILL are dropped.
//
// Ports: clk, reset (async active-low); start/start_addr = miss seen in IDLE and its address;
// MemDataReady = beat valid; idle = FSM in IDLE; MemReadRequest/MemReadAddress = burst request;
// beat_we/beat_off/beat_last = write strobe, line word, final beat; restart = critical word on bus.
module ucsbece154_icache_fill
    import ucsbece154_cache_pkg::*;
#(
    parameter  int BLOCK_WORDS = 4,
    parameter  int ADVANCED    = 0,
    localparam int OB          = offset_bits(BLOCK_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   start_addr,
    input  logic          MemDataReady,
    output logic          idle,
    output logic          MemReadRequest,
    output logic [31:0]   MemReadAddress,
    output logic          beat_we,
    output logic [OB-1:0] beat_off,
    output logic          beat_last,
    output logic          restart
);

    localparam logic [OB:0] LAST_BEAT = (OB+1)'(BLOCK_WORDS - 1);

    fill_state_t   state_q, state_d;
    logic [31:0]   addr_q;
    logic [OB:0]   beat_q;
    logic [OB-1:0] crit;
    logic [OB-1:0] beat_lo;
    logic [OB-1:0] beat_m1;

    assign crit    = addr_q[2 +: OB];
    assign beat_lo = beat_q[OB-1:0];
    assign beat_m1 = beat_lo - (OB)'(1);

    assign idle           = (state_q == ST_IDLE);
    assign MemReadRequest = (state_q == ST_WAIT);
    // The latched address is what memory sees, so CPU address changes mid-miss are harmless.
    assign MemReadAddress = addr_q;

    assign beat_we   = ((state_q == ST_WAIT) || (state_q == ST_FILL)) && MemDataReady
                       && (beat_q <= LAST_BEAT);
    assign beat_last = beat_we && (beat_q == LAST_BEAT);
    // Fires once per miss: every line offset appears on exactly one beat.
    assign restart   = beat_we && (beat_off == crit);

    // Critical-word-first: beat 0 is crit, later beats walk the remaining words in order.
    always_comb begin
        beat_off = beat_lo;
        if (ADVANCED != 0) begin
            if (beat_q == '0) begin
                beat_off = crit;
            end else if (beat_m1 < crit) begin
                beat_off = beat_m1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: begin
                if (beat_last)    state_d = ST_IDLE;
                else if (beat_we) state_d = ST_FILL;
            end
            ST_FILL: if (beat_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (idle && start) begin
                addr_q <= start_addr;
                beat_q <= '0;
            end else if (beat_last) begin
                beat_q <= '0;
            end else if (beat_we) begin
                beat_q <= beat_q + (OB+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ucsbece154_icache.sv
// Two-way set-associative instruction cache with LRU replacement and early restart.
// Latency: hits return combinationally in the request cycle; misses return on the critical beat.
// Backpressure: Ready stays low while a line fill is outstanding, except on the critical beat.
//
// Ports: clk, reset (async active-low); ReadEnable/ReadAddress = CPU fetch; Instruction/Ready =
// fetched word and its valid; MemReadRequest/MemReadAddress = burst request (critical word address);
// MemDataIn/MemDataReady = burst beats from memory.
module ucsbece154_icache
    import ucsbece154_cache_pkg::*;
#(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 2,
    parameter int BLOCK_WORDS = 4,
    parameter int ADVANCED    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int OB = offset_bits(BLOCK_WORDS);
    localparam int IB = index_bits(NUM_SETS);
    localparam int TB = tag_bits(NUM_SETS, BLOCK_WORDS);

    // Tag and data need no reset: valid bits gate every use.
    logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0] lru_q;    // per set: the way that was used least recently
    logic [TB-1:0]       tag_q   [NUM_WAYS][NUM_SETS];
    logic [31:0]         data_q  [NUM_WAYS][NUM_SETS][BLOCK_WORDS];
    logic                victim_q;

    logic [OB-1:0]       rd_off;
    logic [IB-1:0]       rd_idx;
    logic [TB-1:0]       rd_tag;
    logic [IB-1:0]       f_idx;
    logic [TB-1:0]       f_tag;
    logic [NUM_WAYS-1:0] way_hit;
    logic                hit;
    logic                hit_way;
    logic                victim;
    logic                start;
    logic                idle;
    logic                beat_we;
    logic [OB-1:0]       beat_off;
    logic                beat_last;
    logic                restart;
    logic                unused_addr_bits;

    assign rd_off = ReadAddress[2 +: OB];
    assign rd_idx = ReadAddress[2+OB +: IB];
    assign rd_tag = ReadAddress[31 -: TB];
    assign f_idx  = MemReadAddress[2+OB +: IB];
    assign f_tag  = MemReadAddress[31 -: TB];

    assign unused_addr_bits = ^{ReadAddress[1:0], MemReadAddress[1+OB:0]};

    always_comb begin
        way_hit = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_hit[w] = valid_q[w][rd_idx] && (tag_q[w][rd_idx] == rd_tag);
        end
    end

    // Lookups only happen in IDLE; during a fill the arrays belong to the fill.
    assign hit     = ReadEnable && idle && (|way_hit);
    assign hit_way = way_hit[1];
    assign start   = ReadEnable && idle && !(|way_hit);

    // Invalid ways first (way 0 before way 1), otherwise the LRU way.
    assign victim = !valid_q[0][rd_idx] ? 1'b0 :
                    !valid_q[1][rd_idx] ? 1'b1 : lru_q[rd_idx];

    assign Ready       = hit || restart;
    assign Instruction = restart ? MemDataIn :
                         hit     ? data_q[hit_way][rd_idx][rd_off] : 32'h0;

    ucsbece154_icache_fill #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .ADVANCED    (ADVANCED)
    ) u_fill (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (ReadAddress),
        .MemDataReady   (MemDataReady),
        .idle           (idle),
        .MemReadRequest (MemReadRequest),
        .MemReadAddress (MemReadAddress),
        .beat_we        (beat_we),
        .beat_off       (beat_off),
        .beat_last      (beat_last),
        .restart        (restart)
    );

    // The victim is invalidated at miss time, so an abandoned fill leaves the line invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
            end
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            if (start) begin
                victim_q                <= victim;
                valid_q[victim][rd_idx] <= 1'b0;
            end
            if (hit) begin
                lru_q[rd_idx] <= ~hit_way;
            end
            if (beat_last) begin
                valid_q[victim_q][f_idx] <= 1'b1;
                lru_q[f_idx]             <= ~victim_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_q[victim_q][f_idx][beat_off] <= MemDataIn;
        end
        if (beat_last) begin
            tag_q[victim_q][f_idx] <= f_tag;
        end
    end

endmodule
